// File: rtl/mor1kx_wb_arb_multi.sv
// mor1kx_wb_arb_multi
// Multi-channel writeback arbiter. Each execution unit hands its result over
// through a valid/ready handshake into a one-deep per-channel hold buffer.
// On every writeback advance one pending buffer is granted onto the single
// register-file write port (fixed priority or round-robin). A pipeline flush
// discards everything that is buffered and kills the output strobes.
module mor1kx_wb_arb_multi #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_CH               = 4,
    parameter int ARB_MODE             = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   padv_wb_i,
    input  logic                                   pipeline_flush_i,
    input  logic [NUM_CH-1:0]                      ch_valid_i,
    output logic [NUM_CH-1:0]                      ch_ready_o,
    input  logic [NUM_CH*OPTION_OPERAND_WIDTH-1:0] ch_result_i,
    input  logic [NUM_CH*OPTION_RF_ADDR_WIDTH-1:0] ch_rfd_adr_i,
    input  logic [NUM_CH-1:0]                      ch_rf_wb_i,
    input  logic [NUM_CH-1:0]                      ch_except_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]        wb_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]        wb_rfd_adr_o,
    output logic                                   wb_rf_wb_o,
    output logic                                   wb_valid_o,
    output logic                                   wb_except_o,
    output logic [NUM_CH-1:0]                      wb_ch_o
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int A  = OPTION_RF_ADDR_WIDTH;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Pointer reset value makes channel 0 the first candidate after reset.
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_CH - 1);

    // Per-channel hold buffers
    logic [W-1:0]      hold_result_r [NUM_CH];
    logic [A-1:0]      hold_adr_r    [NUM_CH];
    logic [NUM_CH-1:0] hold_rf_wb_r;
    logic [NUM_CH-1:0] hold_except_r;
    logic [NUM_CH-1:0] hold_valid_r;

    // Round-robin pointer: index of the most recently granted channel
    logic [IW-1:0]     rr_ptr_r;

    // Arbitration results
    logic [NUM_CH-1:0] grant_s;
    logic [IW-1:0]     grant_idx_s;
    logic              found_s;
    logic [NUM_CH-1:0] ready_s;

    // Winner contents
    logic [W-1:0]      win_result_s;
    logic [A-1:0]      win_adr_s;
    logic              win_rf_wb_s;
    logic              win_except_s;

    // k-th candidate in search order: plain index in fixed mode, otherwise
    // starting one past the last winner and wrapping.
    function automatic logic [IW-1:0] cand_idx(input logic [IW-1:0] ptr, input int k);
        int sum;
        if (ARB_MODE == 0) begin
            sum = k;
        end else begin
            sum = int'(ptr) + 32'sd1 + k;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end else begin
                sum = sum;
            end
        end
        return sum[IW-1:0];
    endfunction

    // Pick exactly one pending channel when the writeback slot advances.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        if (padv_wb_i && !pipeline_flush_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!found_s && hold_valid_r[cand_idx(rr_ptr_r, k)]) begin
                    grant_s[cand_idx(rr_ptr_r, k)] = 1'b1;
                    grant_idx_s                    = cand_idx(rr_ptr_r, k);
                    found_s                        = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant_s     = '0;
            grant_idx_s = '0;
            found_s     = 1'b0;
        end
    end

    // A buffer accepts when empty or when it drains at this very edge.
    assign ready_s    = {NUM_CH{~pipeline_flush_i}} & (~hold_valid_r | grant_s);
    assign ch_ready_o = ready_s;

    // Route the granted buffer's contents towards the output registers.
    assign win_result_s = hold_result_r[grant_idx_s];
    assign win_adr_s    = hold_adr_r[grant_idx_s];
    assign win_rf_wb_s  = hold_rf_wb_r[grant_idx_s];
    assign win_except_s = hold_except_r[grant_idx_s];

    // Capture new results into hold buffers and retire granted ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold_result_r[i] <= '0;
                hold_adr_r[i]    <= '0;
            end
            hold_rf_wb_r  <= '0;
            hold_except_r <= '0;
            hold_valid_r  <= '0;
        end else if (pipeline_flush_i) begin
            hold_valid_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid_i[i] && ready_s[i]) begin
                    hold_result_r[i] <= ch_result_i[i*W +: W];
                    hold_adr_r[i]    <= ch_rfd_adr_i[i*A +: A];
                    hold_rf_wb_r[i]  <= ch_rf_wb_i[i];
                    hold_except_r[i] <= ch_except_i[i];
                    hold_valid_r[i]  <= 1'b1;
                end else if (grant_s[i]) begin
                    hold_valid_r[i]  <= 1'b0;
                end else begin
                    hold_valid_r[i]  <= hold_valid_r[i];
                end
            end
        end
    end

    // Register the winner onto the RF write port; strobes last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_result_o  <= '0;
            wb_rfd_adr_o <= '0;
            wb_rf_wb_o   <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_except_o  <= 1'b0;
            wb_ch_o      <= '0;
            rr_ptr_r     <= PTR_RST;
        end else if (pipeline_flush_i) begin
            wb_rf_wb_o   <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_except_o  <= 1'b0;
            wb_ch_o      <= '0;
        end else if (found_s) begin
            wb_result_o  <= win_result_s;
            wb_rfd_adr_o <= win_adr_s;
            wb_rf_wb_o   <= win_rf_wb_s & ~win_except_s;
            wb_valid_o   <= 1'b1;
            wb_except_o  <= win_except_s;
            wb_ch_o      <= grant_s;
            rr_ptr_r     <= grant_idx_s;
        end else begin
            wb_rf_wb_o   <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_except_o  <= 1'b0;
            wb_ch_o      <= '0;
        end
    end

endmodule

// File: tb/tb_mor1kx_wb_arb_multi.sv
// Testbench for mor1kx_wb_arb_multi. Two instances share all inputs: one in
// fixed-priority mode, one in round-robin mode. A behavioural model tracks
// pending results per channel and the arbitration order for both.
module tb_mor1kx_wb_arb_multi;

    localparam int N = 4;
    localparam int W = 32;
    localparam int A = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           padv;
    logic           flush;
    logic [N-1:0]   vld;
    logic [N-1:0]   rfwb;
    logic [N-1:0]   exc;
    logic [N*W-1:0] res;
    logic [N*A-1:0] adr;

    logic [N-1:0]   rdy      [2];
    logic [W-1:0]   wres     [2];
    logic [A-1:0]   wadr     [2];
    logic           wrfwb    [2];
    logic           wvalid   [2];
    logic           wexc     [2];
    logic [N-1:0]   wch      [2];

    int n_checks = 0;
    int n_fail   = 0;

    mor1kx_wb_arb_multi #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A),
                          .NUM_CH(N), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .padv_wb_i(padv), .pipeline_flush_i(flush),
        .ch_valid_i(vld), .ch_ready_o(rdy[0]), .ch_result_i(res),
        .ch_rfd_adr_i(adr), .ch_rf_wb_i(rfwb), .ch_except_i(exc),
        .wb_result_o(wres[0]), .wb_rfd_adr_o(wadr[0]), .wb_rf_wb_o(wrfwb[0]),
        .wb_valid_o(wvalid[0]), .wb_except_o(wexc[0]), .wb_ch_o(wch[0]));

    mor1kx_wb_arb_multi #(.OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A),
                          .NUM_CH(N), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .padv_wb_i(padv), .pipeline_flush_i(flush),
        .ch_valid_i(vld), .ch_ready_o(rdy[1]), .ch_result_i(res),
        .ch_rfd_adr_i(adr), .ch_rf_wb_i(rfwb), .ch_except_i(exc),
        .wb_result_o(wres[1]), .wb_rfd_adr_o(wadr[1]), .wb_rf_wb_o(wrfwb[1]),
        .wb_valid_o(wvalid[1]), .wb_except_o(wexc[1]), .wb_ch_o(wch[1]));

    always #5 clk = ~clk;

    // Reference model state, index d = instance (0 fixed, 1 round-robin)
    bit           m_pend [2][N];
    logic [W-1:0] m_res  [2][N];
    logic [A-1:0] m_adr  [2][N];
    bit           m_rfwb [2][N];
    bit           m_exc  [2][N];
    int           m_last [2];
    logic [W-1:0] e_res  [2];
    logic [A-1:0] e_adr  [2];
    bit           e_valid[2];
    bit           e_rfwb [2];
    bit           e_exc  [2];
    logic [N-1:0] e_ch   [2];
    logic [N-1:0] e_rdy  [2];
    logic [N-1:0] a_rdy  [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) m_pend[d][i] = 1'b0;
            m_last[d]  = N - 1;
            e_res[d]   = '0;
            e_adr[d]   = '0;
            e_valid[d] = 1'b0;
            e_rfwb[d]  = 1'b0;
            e_exc[d]   = 1'b0;
            e_ch[d]    = '0;
        end
    endtask

    // Winner of the upcoming edge, or -1 when nobody is granted.
    function automatic int pick(int d);
        int c;
        if (!padv || flush) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (d == 0) ? (k - 1) : ((m_last[d] + k) % N);
            if (m_pend[d][c]) return c;
        end
        return -1;
    endfunction

    // One clock: sample ready before the edge, advance the model, end at negedge.
    task automatic step();
        int g [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            a_rdy[d] = rdy[d];
            g[d]     = pick(d);
            for (int i = 0; i < N; i++)
                e_rdy[d][i] = !flush && (!m_pend[d][i] || g[d] == i);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (flush) begin
                for (int i = 0; i < N; i++) m_pend[d][i] = 1'b0;
                e_valid[d] = 1'b0; e_rfwb[d] = 1'b0; e_exc[d] = 1'b0; e_ch[d] = '0;
            end else begin
                if (g[d] >= 0) begin
                    e_res[d]   = m_res[d][g[d]];
                    e_adr[d]   = m_adr[d][g[d]];
                    e_valid[d] = 1'b1;
                    e_exc[d]   = m_exc[d][g[d]];
                    e_rfwb[d]  = m_rfwb[d][g[d]] && !m_exc[d][g[d]];
                    e_ch[d]    = '0;
                    e_ch[d][g[d]] = 1'b1;
                    m_last[d]  = g[d];
                end else begin
                    e_valid[d] = 1'b0; e_rfwb[d] = 1'b0; e_exc[d] = 1'b0; e_ch[d] = '0;
                end
                for (int i = 0; i < N; i++) begin
                    if (vld[i] && e_rdy[d][i]) begin
                        m_pend[d][i] = 1'b1;
                        m_res[d][i]  = res[i*W +: W];
                        m_adr[d][i]  = adr[i*A +: A];
                        m_rfwb[d][i] = rfwb[i];
                        m_exc[d][i]  = exc[i];
                    end else if (g[d] == i) begin
                        m_pend[d][i] = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ch(int i, bit v, logic [W-1:0] r, logic [A-1:0] a, bit wb, bit ex);
        vld[i]        = v;
        res[i*W +: W] = r;
        adr[i*A +: A] = a;
        rfwb[i]       = wb;
        exc[i]        = ex;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; padv = 1'b0; flush = 1'b0;
        vld = '0; rfwb = '0; exc = '0; res = '0; adr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (wvalid[d] !== 1'b0 || wch[d] !== 4'b0000 || wrfwb[d] !== 1'b0 || wexc[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_strobes dut%0d got valid=%b ch=%b rfwb=%b exc=%b required 0", d, wvalid[d], wch[d], wrfwb[d], wexc[d]);
            end
            n_checks++;
            if (wres[d] !== 32'h0 || wadr[d] !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_data dut%0d got res=%h adr=%0d required 0", d, wres[d], wadr[d]);
            end
            n_checks++;
            if (rdy[d] !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_ready dut%0d got=%b required=1111", d, rdy[d]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        padv = 1'b1;
        set_ch(0, 1'b1, 32'h11, 5'd3, 1'b1, 1'b0);
        set_ch(2, 1'b1, 32'h22, 5'd5, 1'b1, 1'b0);
        step();
        vld = '0;
        step();
        n_checks++;
        if (wch[0] !== 4'b0001 || wres[0] !== 32'h11 || wadr[0] !== 5'd3 || wvalid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fp_first got ch=%b res=%h adr=%0d valid=%b required ch=0001 res=11 adr=3 valid=1", wch[0], wres[0], wadr[0], wvalid[0]);
        end
        n_checks++;
        if (a_rdy[0][2] !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_ch2_ready_wait got=%b required=0", a_rdy[0][2]);
        end
        step();
        n_checks++;
        if (wch[0] !== 4'b0100 || wres[0] !== 32'h22 || wadr[0] !== 5'd5) begin
            n_fail++;
            $display("FAIL fp_second got ch=%b res=%h adr=%0d required ch=0100 res=22 adr=5", wch[0], wres[0], wadr[0]);
        end
        n_checks++;
        if (a_rdy[0][2] !== 1'b1) begin
            n_fail++;
            $display("FAIL fp_ch2_ready_grant got=%b required=1", a_rdy[0][2]);
        end
        step();
        n_checks++;
        if (wvalid[0] !== 1'b0 || wch[0] !== 4'b0000 || wres[0] !== 32'h22) begin
            n_fail++;
            $display("FAIL fp_idle got valid=%b ch=%b res=%h required valid=0 ch=0000 res=22", wvalid[0], wch[0], wres[0]);
        end
    endtask

    task automatic test_except();
        do_reset();
        padv = 1'b1;
        set_ch(1, 1'b1, 32'hAB, 5'd7, 1'b1, 1'b1);
        step();
        vld = '0;
        step();
        n_checks++;
        if (wvalid[0] !== 1'b1 || wexc[0] !== 1'b1 || wrfwb[0] !== 1'b0 || wres[0] !== 32'hAB || wadr[0] !== 5'd7 || wch[0] !== 4'b0010) begin
            n_fail++;
            $display("FAIL except got valid=%b exc=%b rfwb=%b res=%h adr=%0d ch=%b required 1 1 0 ab 7 0010", wvalid[0], wexc[0], wrfwb[0], wres[0], wadr[0], wch[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ch;
        do_reset();
        padv = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 1'b1, 32'h100 + i, 5'(i + 1), 1'b1, 1'b0);
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            exp_ch = '0;
            exp_ch[k % N] = 1'b1;
            n_checks++;
            if (wch[1] !== exp_ch || wres[1] !== 32'h100 + (k % N)) begin
                n_fail++;
                $display("FAIL rr_order slot%0d got ch=%b res=%h required ch=%b res=%h", k, wch[1], wres[1], exp_ch, 32'h100 + (k % N));
            end
            n_checks++;
            if (a_rdy[1][k % N] !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_ready slot%0d got=%b required=1", k, a_rdy[1][k % N]);
            end
            n_checks++;
            if (wch[0] !== 4'b0001) begin
                n_fail++;
                $display("FAIL fp_starve slot%0d got ch=%b required=0001", k, wch[0]);
            end
        end
        vld = '0;
    endtask

    task automatic test_stall();
        do_reset();
        padv = 1'b0;
        set_ch(0, 1'b1, 32'hC0, 5'd1, 1'b1, 1'b0);
        set_ch(3, 1'b1, 32'hC3, 5'd2, 1'b1, 1'b0);
        step();
        vld = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (wvalid[0] !== 1'b0 || wvalid[1] !== 1'b0 || a_rdy[0][0] !== 1'b0 || a_rdy[0][3] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall cyc%0d got valid=%b%b rdy0=%b required valid=00 rdy0[0]=0 rdy0[3]=0", k, wvalid[0], wvalid[1], a_rdy[0]);
            end
        end
        padv = 1'b1;
        step();
        n_checks++;
        if (wch[0] !== 4'b0001 || wch[1] !== 4'b0001 || wres[0] !== 32'hC0) begin
            n_fail++;
            $display("FAIL stall_first got ch=%b/%b res=%h required 0001/0001 c0", wch[0], wch[1], wres[0]);
        end
        step();
        n_checks++;
        if (wch[0] !== 4'b1000 || wch[1] !== 4'b1000 || wres[1] !== 32'hC3) begin
            n_fail++;
            $display("FAIL stall_second got ch=%b/%b res=%h required 1000/1000 c3", wch[0], wch[1], wres[1]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        padv = 1'b0;
        set_ch(0, 1'b1, 32'hF0, 5'd1, 1'b1, 1'b0);
        set_ch(1, 1'b1, 32'hF1, 5'd2, 1'b1, 1'b0);
        step();
        vld = '0;
        flush = 1'b1; padv = 1'b1;
        set_ch(2, 1'b1, 32'hF2, 5'd3, 1'b1, 1'b0);
        step();
        n_checks++;
        if (a_rdy[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_ready_during got=%b required=0000", a_rdy[0]);
        end
        flush = 1'b0; padv = 1'b0; vld = '0;
        #1;
        n_checks++;
        if (rdy[0] !== 4'b1111 || rdy[1] !== 4'b1111 || wvalid[0] !== 1'b0 || wch[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_after got rdy=%b/%b valid=%b ch=%b required 1111/1111 0 0000", rdy[0], rdy[1], wvalid[0], wch[0]);
        end
        padv = 1'b1;
        step();
        n_checks++;
        if (wvalid[0] !== 1'b0 || wvalid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_grant got valid=%b/%b required 0/0", wvalid[0], wvalid[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        padv = 1'b1;
        set_ch(0, 1'b1, 32'hA0, 5'd4, 1'b1, 1'b0);
        set_ch(1, 1'b1, 32'hA1, 5'd6, 1'b1, 1'b0);
        step();
        vld = '0;
        step();
        n_checks++;
        if (wvalid[0] !== 1'b1 || a_rdy[0][1] !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_precond got valid=%b rdy1=%b required valid=1 rdy1=0", wvalid[0], a_rdy[0][1]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (wvalid[d] !== 1'b0 || wch[d] !== 4'b0000 || wres[d] !== 32'h0 || wadr[d] !== 5'd0 || rdy[d] !== 4'b1111) begin
                n_fail++;
                $display("FAIL arst_immediate dut%0d got valid=%b ch=%b res=%h adr=%0d rdy=%b required 0 0000 0 0 1111", d, wvalid[d], wch[d], wres[d], wadr[d], rdy[d]);
            end
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        set_ch(1, 1'b1, 32'hB1, 5'd9, 1'b1, 1'b0);
        set_ch(0, 1'b1, 32'hB0, 5'd8, 1'b1, 1'b0);
        step();
        vld = '0;
        step();
        n_checks++;
        if (wch[1] !== 4'b0001 || wch[0] !== 4'b0001 || wres[1] !== 32'hB0) begin
            n_fail++;
            $display("FAIL arst_first_grant got ch=%b/%b res=%h required 0001/0001 b0", wch[0], wch[1], wres[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            padv  = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            vld   = N'($urandom);
            rfwb  = N'($urandom);
            exc   = N'($urandom_range(0, 7) == 0 ? $urandom : 0);
            for (int i = 0; i < N; i++) begin
                res[i*W +: W] = $urandom;
                adr[i*A +: A] = A'($urandom);
            end
            step();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (a_rdy[d] !== e_rdy[d]) begin
                    n_fail++;
                    $display("FAIL rnd_ready dut%0d cyc%0d got=%b required=%b", d, c, a_rdy[d], e_rdy[d]);
                end
                n_checks++;
                if (wvalid[d] !== e_valid[d] || wch[d] !== e_ch[d] || wrfwb[d] !== e_rfwb[d] || wexc[d] !== e_exc[d]) begin
                    n_fail++;
                    $display("FAIL rnd_strobes dut%0d cyc%0d got v=%b ch=%b wb=%b ex=%b required v=%b ch=%b wb=%b ex=%b", d, c, wvalid[d], wch[d], wrfwb[d], wexc[d], e_valid[d], e_ch[d], e_rfwb[d], e_exc[d]);
                end
                n_checks++;
                if (wres[d] !== e_res[d] || wadr[d] !== e_adr[d]) begin
                    n_fail++;
                    $display("FAIL rnd_data dut%0d cyc%0d got res=%h adr=%0d required res=%h adr=%0d", d, c, wres[d], wadr[d], e_res[d], e_adr[d]);
                end
            end
        end
        vld = '0; padv = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        padv  = 1'b0;
        flush = 1'b0;
        vld   = '0;
        rfwb  = '0;
        exc   = '0;
        res   = '0;
        adr   = '0;
        test_reset();
        test_fixed_priority();
        test_except();
        test_round_robin();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mor1kx_wb_arb_multi.md
Name: mor1kx_wb_arb_multi

Overview:
- Parametrised successor to the single-result RF writeback mux.
- Accepts results from NUM_CH independent execution units (ALU, LSU, MUL/DIV, FPU, ...) through per-channel valid/ready handshakes.
- Buffers one result per channel and arbitrates onto the single RF write port on each writeback advance.
- Sits between the execution units and the register file / exception logic. Supports fixed-priority or round-robin arbitration and pipeline flush.

Parameters:
- OPTION_OPERAND_WIDTH, 32, result data width.
- OPTION_RF_ADDR_WIDTH, 5, destination register address width.
- NUM_CH, 4, number of result channels; legal range 2..8.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- padv_wb_i  in  1  writeback slot advance; a grant may occur only when high.
- pipeline_flush_i  in  1  discard all buffered and output state.
- ch_valid_i  in  NUM_CH  per-channel result valid.
- ch_ready_o  out  NUM_CH  per-channel buffer can accept.
- ch_result_i  in  NUM_CH*OPTION_OPERAND_WIDTH  packed results; channel i occupies bits [i*W +: W].
- ch_rfd_adr_i  in  NUM_CH*OPTION_RF_ADDR_WIDTH  packed destination addresses.
- ch_rf_wb_i  in  NUM_CH  result writes the RF.
- ch_except_i  in  NUM_CH  result carries an exception.
- wb_result_o  out  OPTION_OPERAND_WIDTH  granted result.
- wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  granted destination address.
- wb_rf_wb_o  out  1  RF write strobe.
- wb_valid_o  out  1  a result was granted last edge.
- wb_except_o  out  1  granted result carries an exception.
- wb_ch_o  out  NUM_CH  one-hot granted channel.

Behaviour:
- Reset values: all outputs 0; hold_valid all 0; round-robin pointer = NUM_CH-1, so channel 0 has first priority.
- Per-channel hold register holds result, address, rf_wb, except and hold_valid.
- Capture: at an edge with ch_valid_i[i] & ch_ready_o[i], load the hold register and set hold_valid[i].
- ch_ready_o[i] = ~pipeline_flush_i & (~hold_valid[i] | grant[i]). This is combinational, which allows one result per channel per cycle.
- Grant:
  - grant is combinational: it is one-hot among hold_valid, and all zero unless padv_wb_i & ~pipeline_flush_i.
  - ARB_MODE 0: lowest pending index wins.
  - ARB_MODE 1: search starts at pointer+1 modulo NUM_CH and wraps; the pointer loads the granted index on each grant.
- A channel granted and captured at the same edge keeps hold_valid[i] = 1 with the new contents.
- Output, on an edge with padv_wb_i & ~pipeline_flush_i:
  - If any grant: load the winner into wb_result_o and wb_rfd_adr_o. Set wb_valid_o=1, wb_ch_o=grant, wb_except_o=winner except, wb_rf_wb_o = winner rf_wb & ~winner except.
  - If no grant: wb_valid_o, wb_rf_wb_o, wb_except_o and wb_ch_o go to 0. wb_result_o and wb_rfd_adr_o hold.
- Edge without padv_wb_i: wb_valid_o, wb_rf_wb_o, wb_except_o and wb_ch_o go to 0, so they are single-cycle strobes. Data holds. Hold buffers stay pending.
- Latency: a result captured at edge E0 is visible at the output no earlier than after edge E1, where E1 is the next padv edge at which it wins.
- Flush (highest priority after reset):
  - Clear all hold_valid, wb_valid_o, wb_rf_wb_o, wb_except_o and wb_ch_o.
  - Inputs presented in the flush cycle are not accepted.
  - The round-robin pointer is unchanged; data registers hold.
- Reset mid-operation: immediate return to reset values; pending results are lost.
- No two channels are granted at the same edge. A pending channel never loses data while waiting.

Test Plan:
1. ARB_MODE=0; ch0 and ch2 valid in the same cycle (0x11/r3, 0x22/r5); padv_wb_i high continuously.
   - Cycle after capture: wb_ch_o=0001, result 0x11, adr 3.
   - Next cycle: wb_ch_o=0100, result 0x22, adr 5.
   - ch2 ready stays low until its grant cycle.
2. ARB_MODE=1; all 4 channels kept continuously valid; padv high for 8 cycles.
   - Grants in order ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3, one per cycle.
   - Each channel's ready is high in its own grant cycle.
3. ch1 result 0xAB/r7, rf_wb=1, except=1.
   - Output has wb_valid_o=1, wb_except_o=1, wb_rf_wb_o=0, wb_result_o=0xAB.
4. padv_wb_i held low 5 cycles with ch0 and ch3 pending.
   - No output strobes during the 5 cycles; ch0/ch3 ready low.
   - On padv: ch0 granted, then ch3.
5. ch0 and ch1 pending, pipeline_flush_i for 1 cycle with ch2 valid in that cycle.
   - After the flush edge: all strobes 0 and all ready high.
   - ch2 is not captured, and no grant occurs on the following padv.
6. rst_n asserted low asynchronously between edges while ch1 is pending and wb_valid_o=1.
   - Outputs drop to 0 immediately without a clock edge.
   - After release, the first ch0 and ch1 requests grant ch0 first.
